// File: rtl/div_sequencer_if.sv
// Divide-unit request/response bundle between execute-stage control (master) and the sequencer (slave).
interface div_sequencer_if #(
    parameter int XLEN = 32
);
    logic            start_i;
    logic [1:0]      op_i;
    logic [XLEN-1:0] a_i;
    logic [XLEN-1:0] b_i;
    logic            flush_i;
    logic            busy_o;
    logic            stall_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output start_i, op_i, a_i, b_i, flush_i,
        input  busy_o, stall_o, done_o, result_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i, flush_i,
        output busy_o, stall_o, done_o, result_o
    );
endinterface

// File: rtl/div_sequencer.sv
// Radix-2 restoring DIV/DIVU/REM/REMU sequencer for the execute stage.
// Latency: XLEN+2 cycles normally, 1 cycle for divide-by-zero and signed overflow.
// Backpressure: stall_o holds upstream until DONE; start_i is ignored while busy, flush_i aborts.
module div_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    div_sequencer_if.slave  bus
);
    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            rsel_q, rsel_d;     // 1: remainder, 0: quotient
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;
    logic [XLEN-1:0] quot_q, quot_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] div_q, div_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            launch;
    logic            signed_op;
    logic            ovf;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   trial;

    always_comb begin
        launch    = bus.start_i & ~bus.flush_i;
        signed_op = ~bus.op_i[0];
        ovf       = signed_op
                  & (bus.a_i == {1'b1, {(XLEN-1){1'b0}}})
                  & (bus.b_i == {XLEN{1'b1}});
        abs_a     = (signed_op & bus.a_i[XLEN-1]) ? -bus.a_i : bus.a_i;
        abs_b     = (signed_op & bus.b_i[XLEN-1]) ? -bus.b_i : bus.b_i;
        // The top bit of trial is the borrow: set means the partial remainder was smaller than the divisor.
        shifted   = {rem_q, quot_q[XLEN-1]};
        trial     = shifted - {1'b0, div_q};
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rsel_d   = rsel_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        div_d    = div_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (launch) begin
                    rsel_d = bus.op_i[1];
                    if (bus.b_i == '0) begin
                        result_d = bus.op_i[1] ? bus.a_i : {XLEN{1'b1}};
                        state_d  = S_DONE;
                    end else if (ovf) begin
                        result_d = bus.op_i[1] ? '0 : bus.a_i;
                        state_d  = S_DONE;
                    end else begin
                        quot_d  = abs_a;
                        div_d   = abs_b;
                        rem_d   = '0;
                        qneg_d  = signed_op & (bus.a_i[XLEN-1] ^ bus.b_i[XLEN-1]);
                        rneg_d  = signed_op & bus.a_i[XLEN-1];
                        cnt_d   = CW'(XLEN);
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (bus.flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    quot_d = {quot_q[XLEN-2:0], ~trial[XLEN]};
                    rem_d  = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
                    cnt_d  = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                if (bus.flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    if (rsel_q) begin
                        result_d = rneg_q ? -rem_q : rem_q;
                    end else begin
                        result_d = qneg_q ? -quot_q : quot_q;
                    end
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rsel_q   <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            quot_q   <= '0;
            rem_q    <= '0;
            div_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rsel_q   <= rsel_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            quot_q   <= quot_d;
            rem_q    <= rem_d;
            div_q    <= div_d;
            result_q <= result_d;
        end
    end

    // stall_o drops in DONE so the pipeline captures result_o on the same edge.
    always_comb begin
        bus.busy_o   = (state_q != S_IDLE);
        bus.done_o   = (state_q == S_DONE);
        bus.stall_o  = ((state_q == S_IDLE) & launch)
                     | (state_q == S_CALC)
                     | (state_q == S_FIX);
        bus.result_o = result_q;
    end
endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: normal, special-case, flush, busy-start and reset behaviour.
module tb_div_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;

    div_sequencer_if #(.XLEN(32)) bus ();

    div_sequencer #(.XLEN(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Called just after an edge with the DUT idle; returns in the first idle cycle after DONE.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_cyc, input logic [31:0] exp_res,
                          input int poke);
        int cyc;
        bus.op_i    = op;
        bus.a_i     = a;
        bus.b_i     = b;
        bus.start_i = 1'b1;
        #1;
        check({tag, ".stall0"}, 32'(bus.stall_o), 32'd1);
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        cyc = 1;
        if (exp_cyc == 1) check({tag, ".stall1"}, 32'(bus.stall_o), 32'd0);
        while (!bus.done_o && cyc < 100) begin
            bus.start_i = (cyc == poke);
            if (cyc == poke) begin
                bus.op_i = 2'b01;
                bus.a_i  = 32'd50;
                bus.b_i  = 32'd5;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.start_i = 1'b0;
        check({tag, ".cycle"}, 32'(cyc), 32'(exp_cyc));
        check({tag, ".result"}, bus.result_o, exp_res);
        @(posedge clk); #1;
        check({tag, ".done_pulse"}, 32'(bus.done_o), 32'd0);
        check({tag, ".idle"}, 32'(bus.busy_o), 32'd0);
    endtask

    initial begin
        logic [31:0] held;
        bus.start_i = 1'b0;
        bus.op_i    = 2'b00;
        bus.a_i     = '0;
        bus.b_i     = '0;
        bus.flush_i = 1'b0;
        #1;
        check("rst.busy",   32'(bus.busy_o),  32'd0);
        check("rst.stall",  32'(bus.stall_o), 32'd0);
        check("rst.done",   32'(bus.done_o),  32'd0);
        check("rst.result", bus.result_o,     32'd0);
        #12 rst = 1'b0;
        @(posedge clk); #1;

        run_op("divu_100_7",   2'b01, 32'd100,        32'd7,          34, 32'd14,       0);
        run_op("remu_100_7",   2'b11, 32'd100,        32'd7,          34, 32'd2,        0);
        run_op("div_m7_2",     2'b00, 32'hFFFFFFF9,   32'd2,          34, 32'hFFFFFFFD, 0);
        run_op("rem_m7_2",     2'b10, 32'hFFFFFFF9,   32'd2,          34, 32'hFFFFFFFF, 0);
        run_op("div_7_m2",     2'b00, 32'd7,          32'hFFFFFFFE,   34, 32'hFFFFFFFD, 0);
        run_op("rem_7_m2",     2'b10, 32'd7,          32'hFFFFFFFE,   34, 32'd1,        0);
        run_op("divu_5_0",     2'b01, 32'd5,          32'd0,          1,  32'hFFFFFFFF, 0);
        run_op("remu_5_0",     2'b11, 32'd5,          32'd0,          1,  32'd5,        0);
        run_op("div_5_0",      2'b00, 32'd5,          32'd0,          1,  32'hFFFFFFFF, 0);
        run_op("rem_m5_0",     2'b10, 32'hFFFFFFFB,   32'd0,          1,  32'hFFFFFFFB, 0);
        run_op("div_ovf",      2'b00, 32'h80000000,   32'hFFFFFFFF,   1,  32'h80000000, 0);
        run_op("rem_ovf",      2'b10, 32'h80000000,   32'hFFFFFFFF,   1,  32'd0,        0);
        run_op("divu_max_1",   2'b01, 32'hFFFFFFFF,   32'd1,          34, 32'hFFFFFFFF, 0);
        run_op("div_min_3",    2'b00, 32'h80000000,   32'd3,          34, 32'hD5555556, 0);
        run_op("rem_min_3",    2'b10, 32'h80000000,   32'd3,          34, 32'hFFFFFFFE, 0);
        run_op("remu_busy",    2'b11, 32'd100,        32'd7,          34, 32'd2,        5);

        // Flush in cycle 10 of a DIVU: back to IDLE in cycle 11, relaunch in cycle 12.
        held        = bus.result_o;
        bus.op_i    = 2'b01;
        bus.a_i     = 32'd1000;
        bus.b_i     = 32'd10;
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
            check("flush.no_done_pre", 32'(bus.done_o), 32'd0);
        end
        bus.flush_i = 1'b1;
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
        check("flush.busy",   32'(bus.busy_o),  32'd0);
        check("flush.done",   32'(bus.done_o),  32'd0);
        check("flush.stall",  32'(bus.stall_o), 32'd0);
        check("flush.result", bus.result_o,     held);
        @(posedge clk); #1;
        run_op("divu_after_flush", 2'b01, 32'd1000, 32'd10, 34, 32'd100, 0);

        // Asynchronous reset in the middle of CALC, asserted between edges.
        bus.op_i    = 2'b01;
        bus.a_i     = 32'd100;
        bus.b_i     = 32'd7;
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst.busy",   32'(bus.busy_o),  32'd0);
        check("midrst.stall",  32'(bus.stall_o), 32'd0);
        check("midrst.done",   32'(bus.done_o),  32'd0);
        check("midrst.result", bus.result_o,     32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_op("divu_after_rst", 2'b01, 32'd100, 32'd7, 34, 32'd14, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
